// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone block-copy master with a four-register config slave (SRC/DST/LEN/CTRL) and done interrupt
module wb_dma_copy #(
  parameter int len_width = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i,
  output logic        intr
);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, WR = 2'd2;
  logic [1:0] state, idx;
  logic gap, pend, done, err, ie, busy, wr, ctrl_wr, go, unused;
  logic [31:2] src, dst, rptr, wptr;
  logic [len_width-1:0] len, cnt;
  logic [31:0] dat, wm, rdat;
  assign unused = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[1]};
  assign idx = wb_adr_i[3:2];
  assign wm = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign wr = wb_ack_o & wb_stb_i & wb_cyc_i & wb_we_i;
  assign ctrl_wr = wr & (idx == 2'd3) & wb_sel_i[0];
  // pend covers the single cycle between a LEN==0 START and DONE
  assign busy = (state != IDLE) | pend;
  assign go = ctrl_wr & wb_dat_i[0] & !busy;
  // gap forces cyc low for one cycle after every handshake
  assign m_cyc_o = (state != IDLE) & !gap;
  assign m_stb_o = m_cyc_o;
  assign m_we_o = m_cyc_o & (state == WR);
  assign m_adr_o = {state == WR ? wptr : rptr, 2'b00};
  assign m_dat_o = dat;
  assign m_sel_o = 4'hF;
  assign intr = done & ie;
  assign rdat = idx == 2'd0 ? {src, 2'b00} :
                idx == 2'd1 ? {dst, 2'b00} :
                idx == 2'd2 ? 32'(len) :
                {27'd0, ie, err, done, busy, 1'b0};
  assign wb_dat_o = wb_ack_o ? rdat : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wb_ack_o <= 1'b0;
    else wb_ack_o <= wb_stb_i & wb_cyc_i & !wb_ack_o;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      src <= '0;
      dst <= '0;
      len <= '0;
      ie <= 1'b0;
    end else begin
      if (wr & !busy & (idx == 2'd0)) src <= (src & ~wm[31:2]) | (wb_dat_i[31:2] & wm[31:2]);
      if (wr & !busy & (idx == 2'd1)) dst <= (dst & ~wm[31:2]) | (wb_dat_i[31:2] & wm[31:2]);
      if (wr & !busy & (idx == 2'd2)) len <= (len & ~wm[len_width-1:0]) | (wb_dat_i[len_width-1:0] & wm[len_width-1:0]);
      if (ctrl_wr) ie <= wb_dat_i[4];
    end
  // later assignments win: bus-side DONE/ERR set beats a same-cycle W1C
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gap <= 1'b0;
      pend <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rptr <= '0;
      wptr <= '0;
      cnt <= '0;
      dat <= '0;
    end else begin
      gap <= 1'b0;
      pend <= 1'b0;
      if (ctrl_wr) begin
        done <= done & ~wb_dat_i[2];
        err <= err & ~wb_dat_i[3];
      end
      if (pend) done <= 1'b1;
      if (go) begin
        done <= 1'b0;
        err <= 1'b0;
        rptr <= src;
        wptr <= dst;
        cnt <= len;
        pend <= len == '0;
        state <= len == '0 ? IDLE : RD;
      end
      if (m_cyc_o) begin
        if (m_err_i) begin
          state <= IDLE;
          err <= 1'b1;
          done <= 1'b1;
        end else if (m_ack_i) begin
          gap <= 1'b1;
          if (state == RD) begin
            dat <= m_dat_i;
            state <= WR;
          end else begin
            rptr <= rptr + 30'd1;
            wptr <= wptr + 30'd1;
            cnt <= cnt - len_width'(1);
            done <= cnt == len_width'(1);
            state <= cnt == len_width'(1) ? IDLE : RD;
          end
        end else if (m_rty_i) gap <= 1'b1;
      end
    end
endmodule

// File: tb/tb_wb_dma_copy.sv
// tb_wb_dma_copy: randomized directed bench for wb_dma_copy with a memory slave model and copy reference model
module tb_wb_dma_copy;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0] wb_sel_i = 4'hF;
  logic wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_ack_o;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic [3:0] m_sel_o;
  logic m_we_o, m_cyc_o, m_stb_o, m_ack_i, m_err_i, m_rty_i, intr;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  wb_dma_copy dut (
    .clk(clk), .rst_n(rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i),
    .m_err_i(m_err_i), .m_rty_i(m_rty_i), .intr(intr)
  );
  int unsigned seed;
  function automatic logic [31:0] bg(int i);
    return 32'(i) * 32'h9E3779B1 ^ seed;
  endfunction
  // memory slave: registered responses, one-shot rty/err injection by access index
  logic [31:0] mem [0:1023];
  int acc_n = 0, acc_base = 0, rty_at = -1, err_at = -1;
  logic [31:0] log_adr [$];
  bit log_we [$];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_ack_i <= 1'b0;
      m_err_i <= 1'b0;
      m_rty_i <= 1'b0;
      m_dat_i <= '0;
      for (int i = 0; i < 1024; i++) mem[i] = bg(i);
    end else begin
      m_ack_i <= 1'b0;
      m_err_i <= 1'b0;
      m_rty_i <= 1'b0;
      if (m_cyc_o && m_stb_o && !m_ack_i && !m_err_i && !m_rty_i) begin
        if (acc_n - acc_base == err_at) m_err_i <= 1'b1;
        else if (acc_n - acc_base == rty_at) m_rty_i <= 1'b1;
        else begin
          m_ack_i <= 1'b1;
          log_adr.push_back(m_adr_o);
          log_we.push_back(m_we_o);
          if (m_we_o) mem[m_adr_o[11:2]] = m_dat_o;
          else m_dat_i <= mem[m_adr_o[11:2]];
        end
        acc_n++;
      end
    end
  // bus protocol monitor
  int cyc_cnt = 0, b2b = 0, bad_sig = 0, cyc_n = 0, rty_cyc = -100, re_cyc = -100;
  logic [31:0] rty_adr = '0, re_adr = '0;
  bit prev_cyc = 0, prev_hs = 0, want_re = 0;
  always @(posedge clk) begin
    cyc_n++;
    if (m_cyc_o) cyc_cnt++;
    if (prev_hs && m_cyc_o) b2b++;
    if (m_stb_o !== m_cyc_o || (m_cyc_o && (m_sel_o !== 4'hF || m_adr_o[1:0] !== 2'b00))) bad_sig++;
    if (m_cyc_o && !prev_cyc && want_re) begin
      re_adr = m_adr_o;
      re_cyc = cyc_n;
      want_re = 0;
    end
    if (m_cyc_o && m_rty_i) begin
      rty_adr = m_adr_o;
      rty_cyc = cyc_n;
      want_re = 1;
    end
    prev_hs = m_cyc_o && (m_ack_i || m_err_i || m_rty_i);
    prev_cyc = m_cyc_o;
  end
  logic [31:0] model [0:1023];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] wd, output logic [31:0] rd);
    int n = 0;
    wb_adr_i = adr;
    wb_dat_i = wd;
    wb_we_i = we;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!wb_ack_o && n < 8);
    chk("wb_ack", wb_ack_o, 1);
    rd = wb_dat_o;
    @(posedge clk);
    #1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i = 1'b0;
  endtask
  task automatic wr(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] x;
    wb_xfer(adr, 1'b1, d, x);
  endtask
  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    wb_xfer(adr, 1'b0, '0, d);
  endtask
  task automatic wait_done();
    logic [31:0] c;
    int n = 0;
    do begin
      rd(32'hC, c);
      n++;
    end while (c[1] && n < 400);
    chk("busy_timeout", c[1], 0);
  endtask
  task automatic run_copy(input int s, input int d, input int n, input int ra, input int ea, input bit ie);
    logic [31:0] c;
    int base_log, nack, nw;
    rty_at = ra;
    err_at = ea;
    acc_base = acc_n;
    base_log = log_adr.size();
    wr(32'h0, s);
    wr(32'h4, d);
    wr(32'h8, n);
    wr(32'hC, ie ? 32'h11 : 32'h01);
    wait_done();
    rd(32'hC, c);
    chk("ctrl", c, (ea >= 0 ? 32'hC : 32'h4) | (ie ? 32'h10 : 32'h0));
    chk("intr", intr, ie);
    nack = ea >= 0 ? ea : 2 * n;
    nw = ea >= 0 ? ea / 2 : n;
    chk("log_len", log_adr.size() - base_log, nack);
    for (int k = 0; k < nack && base_log + k < log_adr.size(); k++) begin
      chk("log_adr", log_adr[base_log + k], k % 2 ? d + 4 * (k / 2) : s + 4 * (k / 2));
      chk("log_we", log_we[base_log + k], k % 2);
    end
    for (int i = 0; i < nw; i++) model[d / 4 + i] = model[s / 4 + i];
    for (int i = 0; i <= n; i++) chk("dst_mem", mem[d / 4 + i], model[d / 4 + i]);
    rd(32'h0, c);
    chk("src_kept", c, s);
    rd(32'h8, c);
    chk("len_kept", c, n);
    rty_at = -1;
    err_at = -1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] c;
    int c0, s, d, n, ra;
    bit ie;
    seed = $urandom;
    for (int i = 0; i < 1024; i++) model[i] = bg(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc", m_cyc_o, 0);
    chk("rst_stb", m_stb_o, 0);
    chk("rst_we", m_we_o, 0);
    chk("rst_ack", wb_ack_o, 0);
    chk("rst_intr", intr, 0);
    chk("rst_madr", m_adr_o, 0);
    chk("rst_mdat", m_dat_o, 0);
    chk("rst_wbdat", wb_dat_o, 0);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rd(32'(4 * r), c);
      chk("rst_reg", c, 0);
    end
    run_copy(0, 32'h100, 4, -1, -1, 0);
    run_copy(32'h40, 32'h180, 1, -1, -1, 1);
    wr(32'hC, 32'h14);
    chk("intr_clr", intr, 0);
    rd(32'hC, c);
    chk("ctrl_ie_kept", c, 32'h10);
    c0 = cyc_cnt;
    wr(32'h8, 0);
    wr(32'hC, 32'h11);
    @(posedge clk);
    #1;
    chk("len0_intr", intr, 1);
    rd(32'hC, c);
    chk("len0_ctrl", c, 32'h14);
    chk("len0_no_cyc", cyc_cnt - c0, 0);
    run_copy(32'h80, 32'h200, 4, 2, -1, 0);
    chk("rty_adr", rty_adr, 32'h84);
    chk("reissue_adr", re_adr, 32'h84);
    chk("reissue_gap", re_cyc - rty_cyc, 2);
    run_copy(32'hC0, 32'h280, 3, -1, 3, 0);
    wr(32'h0, 32'h300);
    rd(32'h0, c);
    chk("src_rewrite", c, 32'h300);
    wr(32'hC, 32'h0C);
    rd(32'hC, c);
    chk("w1c_clear", c, 0);
    for (int it = 0; it < 4; it++) begin
      n = $urandom_range(1, 8);
      s = $urandom_range(0, 255) * 4;
      d = (512 + $urandom_range(0, 200)) * 4;
      ra = $urandom_range(0, 1) ? $urandom_range(0, 2 * n - 1) : -1;
      ie = 1'($urandom_range(0, 1));
      run_copy(s, d, n, ra, -1, ie);
    end
    wr(32'h0, 32'h40);
    wr(32'h4, 32'h300);
    wr(32'h8, 8);
    wr(32'hC, 32'h01);
    wr(32'h0, 32'hDEAD);
    rd(32'h0, c);
    chk("src_busy_ignored", c, 32'h40);
    c0 = 0;
    while (!m_cyc_o && c0 < 20) begin
      @(posedge clk);
      #1;
      c0++;
    end
    chk("cyc_seen", m_cyc_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cyc", m_cyc_o, 0);
    chk("abort_we", m_we_o, 0);
    chk("abort_adr", m_adr_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(32'hC, c);
    chk("abort_ctrl", c, 0);
    rd(32'h0, c);
    chk("abort_src", c, 0);
    chk("no_back_to_back", b2b, 0);
    chk("bus_signals", bad_sig, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
